// File: rtl/mgmt_bus_arbiter.sv
// Round-robin arbiter sharing the byte-wide management register bus between NUM_REQ requesters.
// One transaction in flight; reads hold rd_addr and are released by a timeout if the target never answers.
module mgmt_bus_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ-1:0]      req_write_i,
    input  logic [16*NUM_REQ-1:0]   req_addr_i,
    input  logic [8*NUM_REQ-1:0]    req_wdata_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic [NUM_REQ-1:0]      resp_valid_o,
    output logic [7:0]              resp_data_o,
    output logic                    resp_err_o,
    output logic                    rd_en_o,
    output logic [15:0]             rd_addr_o,
    input  logic                    rd_valid_i,
    input  logic [7:0]              rd_data_i,
    output logic                    wr_en_o,
    output logic [15:0]             wr_addr_o,
    output logic [7:0]              wr_data_o
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, READ_WAIT, FLUSH} state_e;

    state_e               state_q, state_d;
    logic [GW-1:0]        last_grant_q, last_grant_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [DW-1:0]        resp_data_q, resp_data_d;
    logic                 resp_err_q, resp_err_d;
    logic                 rd_en_q, rd_en_d;
    logic [AW-1:0]        rd_addr_q, rd_addr_d;
    logic                 wr_en_q, wr_en_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [DW-1:0]        wr_data_q, wr_data_d;

    logic                 found;
    logic [GW-1:0]        win;
    logic [GW-1:0]        cand;
    logic                 cmd_write;
    logic [AW-1:0]        cmd_addr;
    logic [DW-1:0]        cmd_wdata;
    logic                 arb_go;
    logic                 rd_done;
    logic                 tmo_hit;
    logic [NUM_REQ-1:0]   grant_oh;

    // Round-robin scan starting just after the last granted requester
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((32'(last_grant_q) + k) % NUM_REQ);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign cmd_write = req_write_i[win];
    assign cmd_addr  = req_addr_i[32'(win)*AW +: AW];
    assign cmd_wdata = req_wdata_i[32'(win)*DW +: DW];
    // The cycle after a grant is skipped so the winner can retire its request
    assign arb_go    = (state_q == IDLE) && (req_ready_q == '0) && found;
    assign rd_done   = !rd_en_q && rd_valid_i;
    assign tmo_hit   = (cnt_q == CW'(TIMEOUT - 1));
    assign grant_oh  = NUM_REQ'(1) << last_grant_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (arb_go && !cmd_write) state_d = READ_WAIT;
            READ_WAIT: begin
                if (rd_done)      state_d = IDLE;
                else if (tmo_hit) state_d = FLUSH;
            end
            FLUSH:     if (rd_valid_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_data_d  = '0;
        resp_err_d   = 1'b0;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        case (state_q)
            IDLE: begin
                if (arb_go) begin
                    req_ready_d  = NUM_REQ'(1) << win;
                    last_grant_d = win;
                    if (cmd_write) begin
                        wr_en_d      = 1'b1;
                        wr_addr_d    = cmd_addr;
                        wr_data_d    = cmd_wdata;
                        resp_valid_d = NUM_REQ'(1) << win;
                    end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = cmd_addr;
                        cnt_d     = '0;
                    end
                end
            end
            READ_WAIT: begin
                if (rd_done) begin
                    resp_valid_d = grant_oh;
                    resp_data_d  = rd_data_i;
                end else if (tmo_hit) begin
                    resp_valid_d = grant_oh;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= GW'(NUM_REQ - 1);
            cnt_q        <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_err_o   = resp_err_q;
    assign rd_en_o      = rd_en_q;
    assign rd_addr_o    = rd_addr_q;
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;

endmodule
